// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: opcodes, FSM states,
// SRAM size codes and the load/store opcode decoder.
package mem_access_unit_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } mau_state_e;

   typedef struct packed {
      logic       is_load;
      logic       is_store;
      logic [1:0] size;
   } mem_op_t;

   // Classify an opcode; anything that is not a load/store decodes to all-zero.
   function automatic mem_op_t decode_op(input logic [5:0] op);
      mem_op_t d;
      d = '0;
      case (op)
         OP_LB, OP_LBU: begin d.is_load  = 1'b1; d.size = SIZE_BYTE; end
         OP_LH, OP_LHU: begin d.is_load  = 1'b1; d.size = SIZE_HALF; end
         OP_LW:         begin d.is_load  = 1'b1; d.size = SIZE_WORD; end
         OP_SB:         begin d.is_store = 1'b1; d.size = SIZE_BYTE; end
         OP_SH:         begin d.is_store = 1'b1; d.size = SIZE_HALF; end
         OP_SW:         begin d.is_store = 1'b1; d.size = SIZE_WORD; end
         default:       d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data aligner: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to the load opcode.
module mem_load_ext
   import mem_access_unit_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [31:0] shifted;

   // Byte-lane shift followed by opcode-selected extension.
   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (opcode)
         OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  result = {24'h000000, shifted[7:0]};
         OP_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  result = {16'h0000, shifted[15:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-SRAM access unit: decodes the EX/MEM instruction, drives the
// SRAM request/response handshake, aligns load data and generates MEM_stall.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       MEM_in_instruction,
   input  logic [ADDR_W-1:0] MEM_in_data_sram_addr,
   input  logic [DATA_W-1:0] MEM_in_data_sram_wdata,
   input  logic              WB_stall,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [1:0]        data_sram_size,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [3:0]        data_sram_wstrb,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic [DATA_W-1:0] MEM_out_load_data,
   output logic              MEM_out_addr_err,
   output logic              MEM_stall
);

   mau_state_e        state_q;
   logic [DATA_W-1:0] load_buf_q;

   logic [5:0]        opcode;
   mem_op_t           op;
   logic              is_access;
   logic              misaligned;
   logic              issue;
   logic [DATA_W-1:0] ext_data;
   logic              unused_instr;

   assign opcode       = MEM_in_instruction[31:26];
   assign unused_instr = ^MEM_in_instruction[25:0];
   assign op           = decode_op(opcode);
   assign is_access    = op.is_load | op.is_store;

   // Alignment check: halves need addr[0]=0, words need addr[1:0]=0.
   always_comb begin
      misaligned = 1'b0;
      if (is_access) begin
         case (op.size)
            SIZE_HALF: misaligned = MEM_in_data_sram_addr[0];
            SIZE_WORD: misaligned = |MEM_in_data_sram_addr[1:0];
            default:   misaligned = 1'b0;
         endcase
      end
   end

   assign issue            = is_access & ~misaligned;
   assign MEM_out_addr_err = is_access & misaligned;

   // Request is live while a fresh access is decoded in IDLE or while waiting for acceptance.
   assign data_sram_req  = ((state_q == ST_IDLE) & issue) | (state_q == ST_ADDR);
   assign data_sram_wr   = op.is_store;
   assign data_sram_size = op.size;
   assign data_sram_addr = MEM_in_data_sram_addr;

   // Byte-lane strobes and lane-replicated store data.
   always_comb begin
      data_sram_wstrb = '0;
      data_sram_wdata = MEM_in_data_sram_wdata;
      if (op.is_store && !misaligned) begin
         case (op.size)
            SIZE_BYTE: begin
               data_sram_wstrb = 4'b0001 << MEM_in_data_sram_addr[1:0];
               data_sram_wdata = {4{MEM_in_data_sram_wdata[7:0]}};
            end
            SIZE_HALF: begin
               data_sram_wstrb = MEM_in_data_sram_addr[1] ? 4'b1100 : 4'b0011;
               data_sram_wdata = {2{MEM_in_data_sram_wdata[15:0]}};
            end
            default: data_sram_wstrb = 4'b1111;
         endcase
      end
   end

   mem_load_ext u_load_ext (
      .opcode (opcode),
      .offset (MEM_in_data_sram_addr[1:0]),
      .rdata  (data_sram_rdata),
      .result (ext_data)
   );

   // Access sequencer; load_buf keeps the result while WB is not ready for it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         load_buf_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue) state_q <= data_sram_addr_ok ? ST_DATA : ST_ADDR;
            end
            ST_ADDR: begin
               if (data_sram_addr_ok) state_q <= ST_DATA;
            end
            ST_DATA: begin
               if (data_sram_data_ok) begin
                  if (WB_stall) begin
                     load_buf_q <= ext_data;
                     state_q    <= ST_DONE;
                  end else begin
                     state_q    <= ST_IDLE;
                  end
               end
            end
            ST_DONE: begin
               if (!WB_stall) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign MEM_out_load_data = (state_q == ST_DONE) ? load_buf_q : ext_data;

   assign MEM_stall = WB_stall
                    | ((state_q == ST_IDLE) & issue)
                    | (state_q == ST_ADDR)
                    | ((state_q == ST_DATA) & ~data_sram_data_ok);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a load-result scoreboard.
module tb_mem_access_unit;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wb_stall;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] sram_addr;
   logic [3:0]  wstrb;
   logic [31:0] sram_wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [31:0] load_data;
   logic        addr_err;
   logic        stall;

   int n_vec = 0;
   int n_mis = 0;
   logic [31:0] exp_q[$];
   logic [31:0] held;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .MEM_in_instruction     (instr),
      .MEM_in_data_sram_addr  (addr),
      .MEM_in_data_sram_wdata (wdata),
      .WB_stall               (wb_stall),
      .data_sram_req          (req),
      .data_sram_wr           (wr),
      .data_sram_size         (size),
      .data_sram_addr         (sram_addr),
      .data_sram_wstrb        (wstrb),
      .data_sram_wdata        (sram_wdata),
      .data_sram_addr_ok      (addr_ok),
      .data_sram_data_ok      (data_ok),
      .data_sram_rdata        (rdata),
      .MEM_out_load_data      (load_data),
      .MEM_out_addr_err       (addr_err),
      .MEM_stall              (stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_load(input string tag);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, load_data);
      end else begin
         chk(tag, load_data, exp_q.pop_front());
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic look();
      #2;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      instr = {op, 26'h0};
      addr  = a;
      wdata = d;
   endtask

   task automatic bubble();
      instr = '0;
      addr  = '0;
      wdata = '0;
   endtask

   initial begin
      resetn = 1'b0; wb_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
      bubble();
      cyc(); cyc();
      resetn = 1'b1;
      look();
      chk("rst_req",   {31'h0, req},      32'h0);
      chk("rst_stall", {31'h0, stall},    32'h0);
      chk("rst_err",   {31'h0, addr_err}, 32'h0);
      chk("rst_ldata", load_data,         32'h0);

      // SW, zero-wait memory
      cyc();
      drive(OP_SW, 32'h0000_1000, 32'hDEAD_BEEF); addr_ok = 1'b1;
      look();
      chk("sw_req",   {31'h0, req},   32'h1);
      chk("sw_wr",    {31'h0, wr},    32'h1);
      chk("sw_size",  {30'h0, size},  32'h2);
      chk("sw_wstrb", {28'h0, wstrb}, 32'hF);
      chk("sw_wdata", sram_wdata,     32'hDEAD_BEEF);
      chk("sw_addr",  sram_addr,      32'h0000_1000);
      chk("sw_stall0", {31'h0, stall}, 32'h1);
      cyc();
      addr_ok = 1'b0; data_ok = 1'b1;
      look();
      chk("sw_req_data", {31'h0, req},   32'h0);
      chk("sw_stall1",   {31'h0, stall}, 32'h0);
      cyc();
      bubble(); data_ok = 1'b0;
      look();
      chk("sw_idle_req", {31'h0, req}, 32'h0);

      // LB and LBU from byte 3
      for (int k = 0; k < 2; k++) begin
         drive((k == 0) ? OP_LB : OP_LBU, 32'h0000_1003, 32'h0); addr_ok = 1'b1;
         exp_q.push_back((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         look();
         chk("lb_req",   {31'h0, req},   32'h1);
         chk("lb_wr",    {31'h0, wr},    32'h0);
         chk("lb_size",  {30'h0, size},  32'h0);
         chk("lb_wstrb", {28'h0, wstrb}, 32'h0);
         cyc();
         addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h80FF_0000;
         look();
         chk("lb_stall", {31'h0, stall}, 32'h0);
         chk_load((k == 0) ? "lb_data" : "lbu_data");
         cyc();
         bubble(); data_ok = 1'b0; rdata = '0;
      end

      // SH to upper half, acceptance delayed 3 cycles
      drive(OP_SH, 32'h0000_2002, 32'h0000_1234); addr_ok = 1'b0;
      for (int c = 0; c < 4; c++) begin
         addr_ok = (c == 3);
         look();
         chk("sh_req",   {31'h0, req},   32'h1);
         chk("sh_wstrb", {28'h0, wstrb}, 32'hC);
         chk("sh_wdata", sram_wdata,     32'h1234_1234);
         chk("sh_size",  {30'h0, size},  32'h1);
         chk("sh_stall", {31'h0, stall}, 32'h1);
         cyc();
      end
      addr_ok = 1'b0;
      look();
      chk("sh_data_wait_req",   {31'h0, req},   32'h0);
      chk("sh_data_wait_stall", {31'h0, stall}, 32'h1);
      cyc();
      data_ok = 1'b1;
      look();
      chk("sh_data_ok_stall", {31'h0, stall}, 32'h0);
      cyc();
      bubble(); data_ok = 1'b0;

      // Misaligned LH
      drive(OP_LH, 32'h0000_3001, 32'h0); addr_ok = 1'b1;
      look();
      chk("lh_mis_err",   {31'h0, addr_err}, 32'h1);
      chk("lh_mis_req",   {31'h0, req},      32'h0);
      chk("lh_mis_stall", {31'h0, stall},    32'h0);
      cyc();
      look();
      chk("lh_mis_req2", {31'h0, req}, 32'h0);
      cyc();
      bubble(); addr_ok = 1'b0;

      // LH / LHU from upper half, issued while WB_stall is high
      for (int k = 0; k < 2; k++) begin
         drive((k == 0) ? OP_LH : OP_LHU, 32'h0000_5002, 32'h0);
         addr_ok = 1'b1; wb_stall = 1'b1;
         exp_q.push_back((k == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
         look();
         chk("lh_wbs_req", {31'h0, req}, 32'h1);
         cyc();
         addr_ok = 1'b0; wb_stall = 1'b0; data_ok = 1'b1; rdata = 32'h8001_0000;
         look();
         chk("lh_wbs_req2", {31'h0, req}, 32'h0);
         chk_load((k == 0) ? "lh_data" : "lhu_data");
         cyc();
         bubble(); data_ok = 1'b0; rdata = '0;
      end

      // LW completing into DONE because WB is stalled
      drive(OP_LW, 32'h0000_4000, 32'h0); addr_ok = 1'b1;
      exp_q.push_back(32'h1357_9BDF);
      held = 32'h1357_9BDF;
      cyc();
      addr_ok = 1'b0; data_ok = 1'b1; wb_stall = 1'b1; rdata = 32'h1357_9BDF;
      look();
      chk("lw_dok_stall", {31'h0, stall}, 32'h1);
      cyc();
      data_ok = 1'b0; rdata = 32'hAAAA_AAAA;
      look();
      chk("lw_done_req",   {31'h0, req},   32'h0);
      chk("lw_done_stall", {31'h0, stall}, 32'h1);
      chk_load("lw_done_data");
      cyc();
      look();
      chk("lw_done_req2",  {31'h0, req},   32'h0);
      chk("lw_done_data2", load_data,      held);
      cyc();
      wb_stall = 1'b0;
      look();
      chk("lw_release_stall", {31'h0, stall}, 32'h0);
      chk("lw_release_req",   {31'h0, req},   32'h0);
      chk("lw_release_data",  load_data,      held);
      cyc();
      bubble(); rdata = '0;
      look();
      chk("lw_after_ldata", load_data, 32'h0);

      // Reset while waiting in DATA
      drive(OP_LW, 32'h0000_6000, 32'h0); addr_ok = 1'b1;
      cyc();
      addr_ok = 1'b0;
      look();
      chk("rstmid_in_data_stall", {31'h0, stall}, 32'h1);
      resetn = 1'b0;
      bubble();
      cyc();
      resetn = 1'b1;
      look();
      chk("rstmid_req",   {31'h0, req},   32'h0);
      chk("rstmid_stall", {31'h0, stall}, 32'h0);
      chk("rstmid_ldata", load_data,      32'h0);
      // A stray data_ok in IDLE must be ignored; a fresh SB then issues immediately.
      data_ok = 1'b1;
      cyc();
      data_ok = 1'b0;
      drive(OP_SB, 32'h0000_7001, 32'h0000_00AB);
      look();
      chk("sb_req",   {31'h0, req},   32'h1);
      chk("sb_wstrb", {28'h0, wstrb}, 32'h2);
      chk("sb_wdata", sram_wdata,     32'hABAB_ABAB);
      chk("sb_size",  {30'h0, size},  32'h0);
      cyc();
      addr_ok = 1'b1;
      look();
      chk("sb_addr_req", {31'h0, req}, 32'h1);
      cyc();
      addr_ok = 1'b0; data_ok = 1'b1;
      look();
      chk("sb_dok_req",   {31'h0, req},   32'h0);
      chk("sb_dok_stall", {31'h0, stall}, 32'h0);
      cyc();
      bubble(); data_ok = 1'b0;
      look();
      chk("end_req", {31'h0, req}, 32'h0);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_mis++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
